// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I core constants, encodings and FSM state type
package core_pkg;

    localparam int RF_ADD_SIZE = 5;

    localparam logic [2:0] WB_SRC_ALU = 3'b000;
    localparam logic [2:0] WB_SRC_MEM = 3'b001;
    localparam logic [2:0] WB_SRC_SX  = 3'b010;
    localparam logic [2:0] WB_SRC_PC4 = 3'b011;
    localparam logic [2:0] WB_SRC_JB  = 3'b100;

    // Stores reuse the low three encodings (sb/sh/sw).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane steering, load extraction/extension, access checks
//
// Ports:
//   addr_i       low two bits of the effective address
//   funct3_i     access size/signedness
//   wdata_i      raw store data
//   rdata_i      raw word read from the bus
//   be_o         byte enables for the access
//   wdata_o      store data replicated across lanes
//   load_o       selected and extended load value
//   misaligned_o halfword/word access not naturally aligned
//   illegal_o    funct3 is not a valid load/store size
module lsu_align
    import core_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = wdata_i;
        load_o       = 32'd0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (funct3_i)
            F3_LB, F3_LBU: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
                load_o  = (funct3_i == F3_LB) ? {{24{byte_sel[7]}}, byte_sel}
                                              : {24'd0, byte_sel};
            end
            F3_LH, F3_LHU: begin
                misaligned_o = addr_i[0];
                be_o         = 4'b0011 << {addr_i[1], 1'b0};
                wdata_o      = {2{wdata_i[15:0]}};
                load_o       = (funct3_i == F3_LH) ? {{16{half_sel[15]}}, half_sel}
                                                   : {16'd0, half_sel};
            end
            F3_LW: begin
                misaligned_o = |addr_i;
                be_o         = 4'b1111;
                load_o       = rdata_i;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/im_stage.sv
// rtl/im_stage.sv - RV32I memory-access stage with data-bus handshake and MEM/WB register
//
// Ports:
//   i_clk, i_rstn               clock, asynchronous active-low reset
//   i_im_*                      execute-to-memory pipeline register contents
//   o_m_alu_out                 forwarding copy of the ALU result
//   o_mem_stall                 holds IF/ID/IE while an access is outstanding
//   o_mem_fault                 one-cycle pulse: misaligned, illegal funct3 or timeout
//   o_dbus_*/i_dbus_*           data bus request/acknowledge interface
//   o_iwb_*                     memory-to-writeback pipeline register
module im_stage
    import core_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [WIDTH-1:0]       i_im_alu_out,
    input  logic [WIDTH-1:0]       i_im_write_data,
    input  logic                   i_im_mem_we,
    input  logic [2:0]             i_im_funct3,
    input  logic                   i_im_rf_we_ctrl,
    input  logic [2:0]             i_im_rf_wb_src_ctrl,
    input  logic [WIDTH-1:0]       i_im_sx_data,
    input  logic [WIDTH-1:0]       i_im_pc_plus_4,
    input  logic [WIDTH-1:0]       i_im_bu_next_dest_jb,
    input  logic [RF_ADD_SIZE-1:0] i_im_dst,
    output logic [WIDTH-1:0]       o_m_alu_out,
    output logic                   o_mem_stall,
    output logic                   o_mem_fault,
    output logic                   o_dbus_req,
    output logic                   o_dbus_we,
    output logic [WIDTH-1:0]       o_dbus_addr,
    output logic [WIDTH-1:0]       o_dbus_wdata,
    output logic [3:0]             o_dbus_be,
    input  logic                   i_dbus_ack,
    input  logic [WIDTH-1:0]       i_dbus_rdata,
    output logic [WIDTH-1:0]       o_iwb_alu_out,
    output logic [WIDTH-1:0]       o_iwb_mem_data,
    output logic [WIDTH-1:0]       o_iwb_sx_data,
    output logic [WIDTH-1:0]       o_iwb_pc_plus_4,
    output logic [WIDTH-1:0]       o_iwb_bu_next_dest_jb,
    output logic                   o_iwb_rf_we_ctrl,
    output logic [2:0]             o_iwb_rf_wb_src_ctrl,
    output logic [RF_ADD_SIZE-1:0] o_iwb_dst
);

    // Timeout fires in the last permitted WAIT cycle; the counter is cleared
    // on WAIT entry, so this bounds WAIT to ACK_TIMEOUT cycles in total.
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    mem_state_t state_q;
    logic [7:0] cnt_q;
    logic       fault_q;

    logic [3:0]       be;
    logic [WIDTH-1:0] wdata_rep;
    logic [WIDTH-1:0] load_ext;
    logic             misaligned;
    logic             illegal;

    logic is_load;
    logic access;
    logic bad_access;
    logic good_access;
    logic timeout;
    logic abort;

    lsu_align u_lsu_align (
        .addr_i       (i_im_alu_out[1:0]),
        .funct3_i     (i_im_funct3),
        .wdata_i      (i_im_write_data),
        .rdata_i      (i_dbus_rdata),
        .be_o         (be),
        .wdata_o      (wdata_rep),
        .load_o       (load_ext),
        .misaligned_o (misaligned),
        .illegal_o    (illegal)
    );

    always_comb begin
        is_load     = (i_im_rf_wb_src_ctrl == WB_SRC_MEM);
        access      = i_im_mem_we | is_load;
        bad_access  = access & (misaligned | illegal);
        good_access = access & ~bad_access;
        timeout     = (state_q == ST_WAIT) && (cnt_q == TO_LAST);
        // Ack on the timeout cycle still completes the access.
        abort       = good_access & timeout & ~i_dbus_ack;
    end

    assign o_m_alu_out  = i_im_alu_out;
    assign o_mem_stall  = good_access & ~i_dbus_ack & ~timeout;
    assign o_mem_fault  = fault_q;
    assign o_dbus_req   = good_access;
    assign o_dbus_we    = good_access & i_im_mem_we;
    assign o_dbus_addr  = {i_im_alu_out[WIDTH-1:2], 2'b00};
    assign o_dbus_wdata = wdata_rep;
    assign o_dbus_be    = good_access ? be : 4'b0000;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= bad_access | abort;
            case (state_q)
                ST_IDLE: begin
                    if (good_access && !i_dbus_ack) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    // Dropping the access is an upstream protocol error; recover to IDLE.
                    if (i_dbus_ack || timeout || !good_access) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_iwb_alu_out         <= '0;
            o_iwb_mem_data        <= '0;
            o_iwb_sx_data         <= '0;
            o_iwb_pc_plus_4       <= '0;
            o_iwb_bu_next_dest_jb <= '0;
            o_iwb_rf_we_ctrl      <= 1'b0;
            o_iwb_rf_wb_src_ctrl  <= 3'b000;
            o_iwb_dst             <= '0;
        end else if (o_mem_stall || bad_access || abort) begin
            o_iwb_alu_out         <= '0;
            o_iwb_mem_data        <= '0;
            o_iwb_sx_data         <= '0;
            o_iwb_pc_plus_4       <= '0;
            o_iwb_bu_next_dest_jb <= '0;
            o_iwb_rf_we_ctrl      <= 1'b0;
            o_iwb_rf_wb_src_ctrl  <= 3'b000;
            o_iwb_dst             <= '0;
        end else begin
            o_iwb_alu_out         <= i_im_alu_out;
            o_iwb_mem_data        <= is_load ? load_ext : '0;
            o_iwb_sx_data         <= i_im_sx_data;
            o_iwb_pc_plus_4       <= i_im_pc_plus_4;
            o_iwb_bu_next_dest_jb <= i_im_bu_next_dest_jb;
            o_iwb_rf_we_ctrl      <= i_im_rf_we_ctrl;
            o_iwb_rf_wb_src_ctrl  <= i_im_rf_wb_src_ctrl;
            o_iwb_dst             <= i_im_dst;
        end
    end

endmodule

// File: tb/tb_im_stage.sv
// tb/tb_im_stage.sv - directed self-checking bench for im_stage
module tb_im_stage;
    import core_pkg::*;

    localparam int TB_TO = 255;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] alu_out, write_data, sx_data, pc4, jb;
    logic        mem_we, rf_we, ack;
    logic [2:0]  funct3, wb_src;
    logic [4:0]  dst;
    logic [31:0] rdata;

    logic [31:0] m_alu_out, dbus_addr, dbus_wdata;
    logic        mem_stall, mem_fault, dbus_req, dbus_we;
    logic [3:0]  dbus_be;
    logic [31:0] iwb_alu_out, iwb_mem_data, iwb_sx_data, iwb_pc4, iwb_jb;
    logic        iwb_rf_we;
    logic [2:0]  iwb_wb_src;
    logic [4:0]  iwb_dst;

    int n_tests = 0;
    int n_fail  = 0;
    int n_stall;

    always #5 clk = ~clk;

    im_stage #(.WIDTH(32), .ACK_TIMEOUT(TB_TO)) dut (
        .i_clk                 (clk),
        .i_rstn                (rstn),
        .i_im_alu_out          (alu_out),
        .i_im_write_data       (write_data),
        .i_im_mem_we           (mem_we),
        .i_im_funct3           (funct3),
        .i_im_rf_we_ctrl       (rf_we),
        .i_im_rf_wb_src_ctrl   (wb_src),
        .i_im_sx_data          (sx_data),
        .i_im_pc_plus_4        (pc4),
        .i_im_bu_next_dest_jb  (jb),
        .i_im_dst              (dst),
        .o_m_alu_out           (m_alu_out),
        .o_mem_stall           (mem_stall),
        .o_mem_fault           (mem_fault),
        .o_dbus_req            (dbus_req),
        .o_dbus_we             (dbus_we),
        .o_dbus_addr           (dbus_addr),
        .o_dbus_wdata          (dbus_wdata),
        .o_dbus_be             (dbus_be),
        .i_dbus_ack            (ack),
        .i_dbus_rdata          (rdata),
        .o_iwb_alu_out         (iwb_alu_out),
        .o_iwb_mem_data        (iwb_mem_data),
        .o_iwb_sx_data         (iwb_sx_data),
        .o_iwb_pc_plus_4       (iwb_pc4),
        .o_iwb_bu_next_dest_jb (iwb_jb),
        .o_iwb_rf_we_ctrl      (iwb_rf_we),
        .o_iwb_rf_wb_src_ctrl  (iwb_wb_src),
        .o_iwb_dst             (iwb_dst)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [2:0] src,
                         input logic rfwe, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] d);
        mem_we     = we;
        funct3     = f3;
        wb_src     = src;
        rf_we      = rfwe;
        alu_out    = addr;
        write_data = wd;
        dst        = d;
    endtask

    // Single-cycle load with same-cycle ack; checks the extended result.
    task automatic load_now(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rd, input logic [31:0] exp);
        @(negedge clk);
        drive(1'b0, f3, WB_SRC_MEM, 1'b1, addr, 32'd0, 5'd9);
        rdata = rd;
        ack   = 1'b1;
        #1 check({tag, "_stall"}, 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check({tag, "_data"}, iwb_mem_data, exp);
        check({tag, "_rfwe"}, 32'(iwb_rf_we), 32'd1);
    endtask

    initial begin
        rstn    = 1'b0;
        ack     = 1'b0;
        rdata   = 32'd0;
        sx_data = 32'h1111_2222;
        pc4     = 32'h0000_0104;
        jb      = 32'h0000_0200;
        drive(1'b0, 3'b000, WB_SRC_ALU, 1'b0, 32'd0, 32'd0, 5'd0);
        #12;
        check("rst_req",   32'(dbus_req),  32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_fault", 32'(mem_fault), 32'd0);
        check("rst_rfwe",  32'(iwb_rf_we), 32'd0);
        check("rst_alu",   iwb_alu_out,    32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // sw 0x100, same-cycle ack
        @(negedge clk);
        drive(1'b1, F3_LW, WB_SRC_ALU, 1'b0, 32'h100, 32'hDEAD_BEEF, 5'd0);
        ack = 1'b1;
        #1;
        check("sw_req",   32'(dbus_req),  32'd1);
        check("sw_we",    32'(dbus_we),   32'd1);
        check("sw_addr",  dbus_addr,      32'h100);
        check("sw_be",    32'(dbus_be),   32'hF);
        check("sw_wdata", dbus_wdata,     32'hDEAD_BEEF);
        check("sw_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check("sw_rfwe",  32'(iwb_rf_we), 32'd0);
        check("sw_fault", 32'(mem_fault), 32'd0);

        // lb 0x103, ack after 3 cycles
        @(negedge clk);
        drive(1'b0, F3_LB, WB_SRC_MEM, 1'b1, 32'h103, 32'd0, 5'd5);
        rdata = 32'h80FF_FF12;
        ack   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lb_stall", 32'(mem_stall), 32'd1);
            check("lb_addr",  dbus_addr,      32'h100);
            check("lb_be",    32'(dbus_be),   32'h8);
            @(posedge clk); #1;
            check("lb_bubble_we",  32'(iwb_rf_we), 32'd0);
            check("lb_bubble_dst", 32'(iwb_dst),   32'd0);
            @(negedge clk);
        end
        ack = 1'b1;
        #1 check("lb_ack_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check("lb_data",  iwb_mem_data,    32'hFFFF_FF80);
        check("lb_rfwe",  32'(iwb_rf_we),  32'd1);
        check("lb_dst",   32'(iwb_dst),    32'd5);
        check("lb_fault", 32'(mem_fault),  32'd0);

        // sh 0x202, back-to-back with the completing load
        @(negedge clk);
        drive(1'b1, F3_LH, WB_SRC_ALU, 1'b0, 32'h202, 32'h0000_ABCD, 5'd0);
        #1;
        check("sh_be",    32'(dbus_be), 32'hC);
        check("sh_wdata", dbus_wdata,   32'hABCD_ABCD);
        check("sh_addr",  dbus_addr,    32'h200);

        load_now("lhu", F3_LHU, 32'h102, 32'h80FF_FF12, 32'h0000_80FF);
        load_now("lh",  F3_LH,  32'h100, 32'h80FF_FF12, 32'hFFFF_FF12);
        load_now("lbu", F3_LBU, 32'h101, 32'h80FF_FF12, 32'h0000_00FF);

        // lw misaligned
        @(negedge clk);
        drive(1'b0, F3_LW, WB_SRC_MEM, 1'b1, 32'h101, 32'd0, 5'd6);
        ack = 1'b0;
        #1;
        check("mis_req",   32'(dbus_req),  32'd0);
        check("mis_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check("mis_fault", 32'(mem_fault), 32'd1);
        check("mis_rfwe",  32'(iwb_rf_we), 32'd0);

        // ALU op passes through; fault pulse ends
        @(negedge clk);
        drive(1'b0, 3'b000, WB_SRC_ALU, 1'b1, 32'h1234_5678, 32'd0, 5'd7);
        #1;
        check("alu_req", 32'(dbus_req), 32'd0);
        check("alu_fwd", m_alu_out,     32'h1234_5678);
        @(posedge clk); #1;
        check("alu_fault_end", 32'(mem_fault), 32'd0);
        check("alu_out",  iwb_alu_out,    32'h1234_5678);
        check("alu_dst",  32'(iwb_dst),   32'd7);
        check("alu_sx",   iwb_sx_data,    32'h1111_2222);
        check("alu_pc4",  iwb_pc4,        32'h0000_0104);
        check("alu_jb",   iwb_jb,         32'h0000_0200);
        check("alu_mem",  iwb_mem_data,   32'd0);

        // illegal funct3
        @(negedge clk);
        drive(1'b0, 3'b011, WB_SRC_MEM, 1'b1, 32'h100, 32'd0, 5'd8);
        #1 check("ill_req", 32'(dbus_req), 32'd0);
        @(posedge clk); #1;
        check("ill_fault", 32'(mem_fault), 32'd1);
        check("ill_rfwe",  32'(iwb_rf_we), 32'd0);

        // timeout with no ack
        @(negedge clk);
        drive(1'b0, F3_LW, WB_SRC_MEM, 1'b1, 32'h300, 32'd0, 5'd10);
        n_stall = 0;
        #1;
        while (mem_stall && n_stall < 400) begin
            n_stall++;
            @(negedge clk); #1;
        end
        check("to_stall_cycles", 32'(n_stall), 32'(TB_TO));
        @(posedge clk); #1;
        check("to_fault", 32'(mem_fault), 32'd1);
        check("to_rfwe",  32'(iwb_rf_we), 32'd0);
        @(negedge clk);
        drive(1'b0, 3'b000, WB_SRC_ALU, 1'b0, 32'd0, 32'd0, 5'd0);
        @(posedge clk); #1;
        check("to_fault_end", 32'(mem_fault), 32'd0);

        // ack exactly on the timeout cycle
        @(negedge clk);
        drive(1'b0, F3_LW, WB_SRC_MEM, 1'b1, 32'h300, 32'd0, 5'd11);
        repeat (TB_TO) @(negedge clk);
        ack   = 1'b1;
        rdata = 32'hCAFE_F00D;
        #1 check("toack_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check("toack_fault", 32'(mem_fault), 32'd0);
        check("toack_data",  iwb_mem_data,   32'hCAFE_F00D);
        check("toack_rfwe",  32'(iwb_rf_we), 32'd1);

        // reset asserted while waiting
        @(negedge clk);
        ack = 1'b0;
        drive(1'b0, F3_LW, WB_SRC_MEM, 1'b1, 32'h400, 32'd0, 5'd12);
        @(posedge clk);
        @(negedge clk); #2;
        rstn = 1'b0;
        drive(1'b0, 3'b000, WB_SRC_ALU, 1'b0, 32'd0, 32'd0, 5'd0);
        #1;
        check("rw_req",   32'(dbus_req),  32'd0);
        check("rw_rfwe",  32'(iwb_rf_we), 32'd0);
        check("rw_dst",   32'(iwb_dst),   32'd0);
        check("rw_mem",   iwb_mem_data,   32'd0);
        @(negedge clk);
        rstn = 1'b1;
        ack  = 1'b1;
        #1 check("late_ack_req", 32'(dbus_req), 32'd0);
        @(posedge clk); #1;
        check("late_ack_fault", 32'(mem_fault), 32'd0);
        check("late_ack_rfwe",  32'(iwb_rf_we), 32'd0);
        @(negedge clk);
        ack = 1'b0;
        drive(1'b0, 3'b000, WB_SRC_ALU, 1'b1, 32'h0BAD_F00D, 32'd0, 5'd3);
        @(posedge clk); #1;
        check("post_rst_alu",  iwb_alu_out,    32'h0BAD_F00D);
        check("post_rst_rfwe", 32'(iwb_rf_we), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
